dppm_decoder: RTL and testbench

- Receive-side stage directly downstream of the D-PPM LED encoder.
- Samples the photodiode input and detects rising edges.
- Measures the spacing between consecutive pulses and rebuilds the frame, LSB first.
- Delivers the frame to the link layer with a one-cycle valid strobe, or flags an error and aborts the frame.

---
 rtl/dppm_decoder_pkg.sv | 29 ++
 rtl/dppm_edge_detect.sv | 43 ++++
 rtl/dppm_decoder.sv | 126 ++++++++++++
 tb/tb_dppm_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dppm_decoder_pkg.sv
// Shared definitions for the D-PPM receive path: frame and timing limits,
// gap-counter thresholds and the decoder state encoding.
package dppm_decoder_pkg;

   localparam int FRAME_SIZE    = 32;  // data bits per frame, same as the encoder
   localparam int THRESHOLD     = 12;  // spacing <= THRESHOLD is a 0, above is a 1
   localparam int MIN_SPACING   = 4;   // spacing below this is a glitch
   localparam int TIMEOUT       = 24;  // longest legal spacing inside a frame
   localparam int CNT_W         = 6;   // gap counter width, holds TIMEOUT+1
   localparam int IDX_W         = $clog2(FRAME_SIZE);

   // Nominal encoder spacings; the threshold sits between them.
   localparam int INTERVAL_LOW  = 8;
   localparam int INTERVAL_HIGH = 16;

   // The gap counter reads S-1 during the cycle of an edge with spacing S,
   // so every spacing limit is expressed one lower on the counter.
   localparam logic [CNT_W-1:0] GAP_MIN      = CNT_W'(MIN_SPACING - 1);
   localparam logic [CNT_W-1:0] GAP_ZERO_MAX = CNT_W'(THRESHOLD - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_SAT      = CNT_W'(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(FRAME_SIZE - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

endpackage

// File: rtl/dppm_edge_detect.sv
// Sensor sampling and rising-edge pulse generation.
// DPPM_DECODER_SYNC_EN: when defined, the sensor first passes through a
// two-flop synchronizer (real hardware); otherwise it is registered once
// (loopback simulation). Edge spacing is identical in both builds.
module dppm_edge_detect (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_sensor,
   output logic o_edge
);

   logic w_level;
   logic r_sample;
   logic r_prev;

`ifdef DPPM_DECODER_SYNC_EN
   logic [1:0] r_sync;

   // Two-stage metastability synchronizer for the asynchronous photodiode.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_sync <= 2'b00;
      else         r_sync <= {r_sync[0], i_sensor};
   end

   assign w_level = r_sync[1];
`else
   assign w_level = i_sensor;
`endif

   // Sample register plus one cycle of history for edge detection.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_sample <= 1'b0;
         r_prev   <= 1'b0;
      end else begin
         r_sample <= w_level;
         r_prev   <= r_sample;
      end
   end

   assign o_edge = r_sample & ~r_prev;

endmodule

// File: rtl/dppm_decoder.sv
// D-PPM receiver: measures pulse spacing, rebuilds the frame LSB first and
// strobes valid on completion or error on a glitch/timeout.
// DPPM_DECODER_SYNC_EN selects the synchronized sample path in dppm_edge_detect.
module dppm_decoder
   import dppm_decoder_pkg::*;
(
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_sensor,
   output logic [FRAME_SIZE-1:0] o_data,
   output logic                  o_valid,
   output logic                  o_error,
   output logic                  o_busy
);

   logic                  w_edge;
   logic                  w_bit;
   logic                  w_store;
   logic                  w_load;
   logic                  w_valid_next;
   logic                  w_error_next;
   logic [IDX_W-1:0]      w_index_next;
   logic [FRAME_SIZE-1:0] w_frame;
   state_t                w_state_next;

   state_t                r_state;
   logic [CNT_W-1:0]      r_gap;
   logic [IDX_W-1:0]      r_index;
   logic [FRAME_SIZE-1:0] r_shadow;
   logic [FRAME_SIZE-1:0] r_data;
   logic                  r_valid;
   logic                  r_error;

   dppm_edge_detect u_edge (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_sensor (i_sensor),
      .o_edge   (w_edge)
   );

   // A spacing above the threshold decodes as 1.
   assign w_bit = (r_gap > GAP_ZERO_MAX);

   // Completed frame: stored bits plus the bit arriving on the final edge.
   always_comb begin
      w_frame                 = r_shadow;
      w_frame[FRAME_SIZE-1]   = w_bit;
   end

   // Next-state logic: start detection, bit classification, completion and aborts.
   always_comb begin
      w_state_next = r_state;
      w_index_next = r_index;
      w_store      = 1'b0;
      w_load       = 1'b0;
      w_valid_next = 1'b0;
      w_error_next = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_edge) begin
               w_state_next = RECV;
               w_index_next = '0;
            end
         end
         RECV: begin
            if (w_edge) begin
               if (r_gap < GAP_MIN) begin
                  w_error_next = 1'b1;
                  w_state_next = IDLE;
               end else if (r_index == IDX_LAST) begin
                  w_load       = 1'b1;
                  w_valid_next = 1'b1;
                  w_state_next = IDLE;
               end else begin
                  w_store      = 1'b1;
                  w_index_next = r_index + 1'b1;
               end
            end else if (r_gap == GAP_LAST) begin
               // No edge at S = TIMEOUT: the frame cannot continue legally.
               w_error_next = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Gap counter: restart on each edge, otherwise count up and saturate.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset)              r_gap <= '0;
      else if (w_edge)          r_gap <= '0;
      else if (r_gap != GAP_SAT) r_gap <= r_gap + 1'b1;
   end

   // State, bit index and one-cycle status strobes.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_index <= '0;
         r_valid <= 1'b0;
         r_error <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_index <= w_index_next;
         r_valid <= w_valid_next;
         r_error <= w_error_next;
      end
   end

   // Shadow register collects bits; output data only changes on a good frame.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_shadow <= '0;
         r_data   <= '0;
      end else begin
         if (w_store) r_shadow[r_index] <= w_bit;
         if (w_load)  r_data            <= w_frame;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_error = r_error;
   assign o_busy  = (r_state == RECV);

endmodule

// File: tb/tb_dppm_decoder.sv
// Self-checking bench for dppm_decoder: directed pulse trains, a cycle-level
// spacing model compared every cycle, and literal checks on decoded frames.
module tb_dppm_decoder;
   import dppm_decoder_pkg::*;

`ifdef DPPM_DECODER_SYNC_EN
   localparam int D = 3;   // sensor -> edge latency
`else
   localparam int D = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sensor = 1'b0;
   logic [31:0] data;
   logic        valid;
   logic        error;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_rise = 0;
   int n_valid = 0;
   int n_err = 0;
   int err_cyc = 0;
   logic [31:0] vq[$];
   logic [31:0] mdl_data = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dppm_decoder dut (
      .i_clock  (clk),
      .i_reset  (rst),
      .i_sensor (sensor),
      .o_data   (data),
      .o_valid  (valid),
      .o_error  (error),
      .o_busy   (busy)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model: edges from the driven sensor history, spacing by cycle numbers.
   initial begin
      logic q[$];
      bit   m_busy;
      int   m_last, m_cnt, m_cyc, s;
      logic [31:0] m_bits;
      logic e_valid, e_error, e_m;
      m_busy = 0; m_last = 0; m_cnt = 0; m_cyc = 0; m_bits = '0;
      forever begin
         @(negedge clk);
         m_cyc++;
         if (rst) begin
            q = {};
            for (int i = 0; i < D + 3; i++) q.push_front(1'b0);
            m_busy = 0; m_cnt = 0; mdl_data = '0;
         end else begin
            q.push_front(sensor);
            if (q.size() > D + 3) void'(q.pop_back());
            e_m = q[D+1] && !q[D+2];
            e_valid = 0; e_error = 0;
            if (e_m) begin
               if (!m_busy) begin
                  m_busy = 1; m_cnt = 0;
               end else begin
                  s = (m_cyc - 1) - m_last;
                  if (s < MIN_SPACING) begin
                     e_error = 1; m_busy = 0;
                  end else begin
                     m_bits[m_cnt] = (s > THRESHOLD);
                     m_cnt++;
                     if (m_cnt == FRAME_SIZE) begin
                        mdl_data = m_bits; e_valid = 1; m_busy = 0;
                     end
                  end
               end
               m_last = m_cyc - 1;
            end else if (m_busy && ((m_cyc - 1) - m_last) == TIMEOUT) begin
               e_error = 1; m_busy = 0;
            end
            check("valid", 32'(valid), 32'(e_valid));
            check("error", 32'(error), 32'(e_error));
            check("busy",  32'(busy),  32'(m_busy));
            check("data",  data, mdl_data);
         end
      end
   end

   // Strobe monitor for literal checks.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid) begin
            n_valid <= n_valid + 1;
            vq.push_back(data);
            $display("[TB] valid data=%h cycle=%0d", data, cyc);
         end
         if (error) begin
            n_err   <= n_err + 1;
            err_cyc <= cyc;
            $display("[TB] error strobe cycle=%0d", cyc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle light pulse; the next rise comes s cycles after this one.
   task automatic pulse(input int s);
      sensor = 1'b1;
      last_rise = cyc;
      tick(1);
      sensor = 1'b0;
      tick(s - 1);
   endtask

   task automatic send_spacings(input int sq[$], input int tail);
      foreach (sq[i]) pulse(sq[i]);
      pulse(tail);
   endtask

   task automatic send_frame(input logic [31:0] d, input int tail, input int npulses);
      int sq[$];
      for (int k = 0; k < 32; k++) sq.push_back(d[k] ? INTERVAL_HIGH : INTERVAL_LOW);
      while (sq.size() > npulses - 1) void'(sq.pop_back());
      if (npulses == 33) send_spacings(sq, tail);
      else begin
         foreach (sq[i]) pulse(sq[i]);
      end
   endtask

   initial begin
      int sq[$];
      int v0, e0;
      #1 rst = 1'b1;
      tick(3);
      check("reset_data",  data, 32'h0);
      check("reset_valid", 32'(valid), 32'h0);
      check("reset_busy",  32'(busy), 32'h0);
      check("reset_error", 32'(error), 32'h0);
      rst = 1'b0;
      tick(4);

      // Nominal frame.
      send_frame(32'hA5A50F0F, 20, 33);
      check("f1_nvalid", 32'(n_valid), 32'd1);
      check("f1_data", vq[0], 32'hA5A50F0F);
      check("f1_model_pin", mdl_data, 32'hA5A50F0F);
      check("f1_nerr", 32'(n_err), 32'd0);

      // Boundary spacings 4,12,13,24 -> bits 0,0,1,1 repeating.
      sq = {};
      for (int k = 0; k < 32; k++) begin
         case (k % 4)
            0: sq.push_back(4);
            1: sq.push_back(12);
            2: sq.push_back(13);
            default: sq.push_back(24);
         endcase
      end
      send_spacings(sq, 20);
      check("bnd_nvalid", 32'(n_valid), 32'd2);
      check("bnd_data", vq[1], 32'hCCCCCCCC);
      check("bnd_model_pin", mdl_data, 32'hCCCCCCCC);

      // Glitch: spacing 3 aborts, data unchanged.
      sq = {3};
      send_spacings(sq, 30);
      check("glitch_nerr", 32'(n_err), 32'd1);
      check("glitch_data", data, 32'hCCCCCCCC);
      check("glitch_busy", 32'(busy), 32'h0);

      // Timeout: start + 10 bits then silence.
      sq = {};
      for (int k = 0; k < 10; k++) sq.push_back(INTERVAL_LOW);
      send_spacings(sq, 40);
      check("to_nerr", 32'(n_err), 32'd2);
      check("to_latency", 32'(err_cyc - last_rise), 32'(D + TIMEOUT + 1));
      check("to_busy", 32'(busy), 32'h0);
      check("to_data", data, 32'hCCCCCCCC);
      send_frame(32'h12345678, 20, 33);
      check("to_next_data", vq[2], 32'h12345678);

      // Asynchronous reset mid-frame, checked before any clock edge.
      v0 = n_valid;
      send_frame(32'h0F0F0F0F, 0, 18);
      #2 rst = 1'b1;
      #1;
      check("arst_busy",  32'(busy), 32'h0);
      check("arst_data",  data, 32'h0);
      check("arst_valid", 32'(valid), 32'h0);
      tick(2);
      rst = 1'b0;
      tick(30);
      check("arst_novalid", 32'(n_valid), 32'(v0));
      send_frame(32'hFFFFFFFF, 20, 33);
      check("arst_next", vq[3], 32'hFFFFFFFF);

      // Back-to-back frames, second start one cycle after valid.
      send_frame(32'h00000001, 2, 33);
      send_frame(32'h80000000, 20, 33);
      check("b2b_nvalid", 32'(n_valid), 32'd6);
      check("b2b_first", vq[4], 32'h00000001);
      check("b2b_second", vq[5], 32'h80000000);

      // Sensor held high: single edge, so only a start then a timeout.
      e0 = n_err;
      sensor = 1'b1;
      tick(40);
      sensor = 1'b0;
      tick(10);
      check("held_nerr", 32'(n_err - e0), 32'd1);
      check("held_nvalid", 32'(n_valid), 32'd6);

      tick(5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
